// File: rtl/regwrite_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module   : regwrite_pkg
// Brief    : Shared types and helpers for the register-write control pipeline.
// Revision : 1.0 - initial release
// ============================================================================
package regwrite_pkg;

    localparam int PKG_SEL_W = 2;
    localparam int PKG_RD_W  = 5;

    // Architectural zero register; writes to it are architecturally discarded.
    localparam logic [PKG_RD_W-1:0] XZR_ADDR = '1;

    typedef struct packed {
        logic                 v;
        logic                 wr;
        logic [PKG_SEL_W-1:0] sel;
        logic [PKG_RD_W-1:0]  rd;
    } wb_ctrl_t;

    function automatic int stage_idx_w(input int depth);
        return $clog2(depth);
    endfunction

endpackage
`default_nettype wire

// File: rtl/regwrite_pipe_stage.sv
`default_nettype none
// ============================================================================
// Module   : regwrite_pipe_stage
// Brief    : One write-control stage with hold and valid-kill.
// Revision : 1.0 - initial release
// ============================================================================
module regwrite_pipe_stage
    import regwrite_pkg::*;
(
    input  logic     clk,
    input  logic     rst_n_i,
    input  logic     hold_i,
    input  logic     kill_i,
    input  wb_ctrl_t d_i,
    output wb_ctrl_t q_o
);

    wb_ctrl_t stage_d;
    wb_ctrl_t stage_q;

    // Kill only clears valid; the payload follows the normal hold/load path.
    always_comb begin
        stage_d = hold_i ? stage_q : d_i;
        if (kill_i) begin
            stage_d.v = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n_i) begin
        if (!rst_n_i) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign q_o = stage_q;

endmodule
`default_nettype wire

// File: rtl/regwrite_pipe.sv
`default_nettype none
// ============================================================================
// Module   : regwrite_pipe
// Brief    : DEPTH-stage register-write control delay line with stall, flush
//            and youngest-producer hazard queries.
// Options  : REGWRITE_PIPE_XZR_FILTER_EN - drop writes to XZR at entry.
// Revision : 1.0 - initial release
// ============================================================================
module regwrite_pipe
    import regwrite_pkg::*;
#(
    parameter  int DEPTH = 4,
    parameter  int SEL_W = PKG_SEL_W,
    parameter  int RD_W  = PKG_RD_W,
    parameter  int NQ    = 2,
    parameter  int KILL  = 2,
    localparam int SW    = stage_idx_w(DEPTH)
)(
    input  logic                clk,
    input  logic                reset,        // asynchronous, active-low
    input  logic                valid_i,
    input  logic                RegWrt,
    input  logic [SEL_W-1:0]    RegWData,
    input  logic [RD_W-1:0]     Rd,
    input  logic                stall,
    input  logic                flush,
    input  logic [NQ*RD_W-1:0]  q_rd,
    output logic [NQ-1:0]       q_hit,
    output logic [NQ*SW-1:0]    q_stage,
    output logic                RegWrtO,
    output logic [SEL_W-1:0]    RegWDataO,
    output logic [RD_W-1:0]     RdO
);

    wb_ctrl_t stage_q [DEPTH];
    wb_ctrl_t entry_d;
    wb_ctrl_t tail_q;
    logic     wr_in;

`ifdef REGWRITE_PIPE_XZR_FILTER_EN
    // A write to XZR is dropped here so it can neither commit nor raise a hit.
    assign wr_in = RegWrt & (Rd != XZR_ADDR);
`else
    assign wr_in = RegWrt;
`endif

    assign entry_d = '{v: valid_i, wr: wr_in, sel: RegWData, rd: Rd};

    for (genvar s = 0; s < DEPTH; s++) begin : g_stage
        wb_ctrl_t stage_d;

        if (s == 0) begin : g_head
            assign stage_d = entry_d;
        end else begin : g_body
            assign stage_d = stage_q[s-1];
        end

        regwrite_pipe_stage u_stage (
            .clk     (clk),
            .rst_n_i (reset),
            .hold_i  (stall),
            .kill_i  (flush && (s < KILL)),
            .d_i     (stage_d),
            .q_o     (stage_q[s])
        );
    end

    // Stall gates the strobe so an entry parked in the last stage commits once.
    assign tail_q    = stage_q[DEPTH-1];
    assign RegWrtO   = tail_q.v & tail_q.wr & ~stall;
    assign RegWDataO = tail_q.sel;
    assign RdO       = tail_q.rd;

    for (genvar k = 0; k < NQ; k++) begin : g_query
        logic [RD_W-1:0]  addr;
        logic [DEPTH-1:0] match;
        logic [SW-1:0]    idx;

        assign addr = q_rd[k*RD_W +: RD_W];

        always_comb begin
            for (int s = 0; s < DEPTH; s++) begin
                match[s] = stage_q[s].v & stage_q[s].wr & (stage_q[s].rd == addr);
            end
        end

        // Scan oldest to youngest so the youngest producer overwrites last.
        always_comb begin
            idx = '0;
            for (int s = DEPTH - 1; s >= 0; s--) begin
                if (match[s]) begin
                    idx = SW'(s);
                end
            end
        end

        assign q_hit[k]             = |match;
        assign q_stage[k*SW +: SW]  = idx;
    end

endmodule
`default_nettype wire

// File: tb/tb_regwrite_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_regwrite_pipe
// Brief    : Self-checking bench for regwrite_pipe against a stage-list model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regwrite_pipe;

    localparam int DEPTH = 4;
    localparam int SEL_W = 2;
    localparam int RD_W  = 5;
    localparam int NQ    = 2;
    localparam int KILL  = 2;
    localparam int SW    = $clog2(DEPTH);

    logic              clk      = 1'b0;
    logic              reset    = 1'b0;
    logic              valid_i  = 1'b0;
    logic              RegWrt   = 1'b0;
    logic [SEL_W-1:0]  RegWData = '0;
    logic [RD_W-1:0]   Rd       = '0;
    logic              stall    = 1'b0;
    logic              flush    = 1'b0;
    logic [NQ*RD_W-1:0] q_rd    = '0;
    logic [NQ-1:0]     q_hit;
    logic [NQ*SW-1:0]  q_stage;
    logic              RegWrtO;
    logic [SEL_W-1:0]  RegWDataO;
    logic [RD_W-1:0]   RdO;

    always #5 clk = ~clk;

    regwrite_pipe #(
        .DEPTH (DEPTH),
        .SEL_W (SEL_W),
        .RD_W  (RD_W),
        .NQ    (NQ),
        .KILL  (KILL)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .valid_i   (valid_i),
        .RegWrt    (RegWrt),
        .RegWData  (RegWData),
        .Rd        (Rd),
        .stall     (stall),
        .flush     (flush),
        .q_rd      (q_rd),
        .q_hit     (q_hit),
        .q_stage   (q_stage),
        .RegWrtO   (RegWrtO),
        .RegWDataO (RegWDataO),
        .RdO       (RdO)
    );

    // Reference: list of in-flight entries, index 0 = youngest (stage 1).
    typedef struct {
        bit v;
        bit wr;
        int sel;
        int rd;
    } ent_t;

    ent_t m [DEPTH];

    int n_checks   = 0;
    int n_errors   = 0;
    int cyc        = 0;
    int commits    = 0;
    int commit_cyc = -1;
    int commit_rd  = -1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_clear();
        for (int s = 0; s < DEPTH; s++) m[s] = '{1'b0, 1'b0, 0, 0};
    endtask

    task automatic model_step();
        ent_t nxt [DEPTH];
        bit   wr_eff;
        wr_eff = RegWrt;
`ifdef REGWRITE_PIPE_XZR_FILTER_EN
        if (int'(Rd) == 31) wr_eff = 1'b0;
`endif
        if (stall) begin
            nxt = m;
        end else begin
            nxt[0] = '{valid_i, wr_eff, int'(RegWData), int'(Rd)};
            for (int s = 1; s < DEPTH; s++) nxt[s] = m[s-1];
        end
        if (flush) begin
            for (int s = 0; s < KILL; s++) nxt[s].v = 1'b0;
        end
        m = nxt;
    endtask

    task automatic check_model();
        bit exp_w;
        exp_w = m[DEPTH-1].v && m[DEPTH-1].wr && !stall;
        chk("RegWrtO", 32'(RegWrtO), 32'(exp_w));
        chk("RegWDataO", 32'(RegWDataO), m[DEPTH-1].sel);
        chk("RdO", 32'(RdO), m[DEPTH-1].rd);
        for (int k = 0; k < NQ; k++) begin
            int qa;
            bit hit;
            int st;
            qa  = int'(q_rd[k*RD_W +: RD_W]);
            hit = 1'b0;
            st  = 0;
            for (int s = 0; s < DEPTH; s++) begin
                if (!hit && m[s].v && m[s].wr && m[s].rd == qa) begin
                    hit = 1'b1;
                    st  = s;
                end
            end
            chk("q_hit", 32'(q_hit[k]), 32'(hit));
            chk("q_stage", 32'(q_stage[k*SW +: SW]), st);
        end
        if (RegWrtO === 1'b1) begin
            commits++;
            commit_cyc = cyc;
            commit_rd  = int'(RdO);
        end
    endtask

    // One clock: drive, check settled outputs, take the edge, advance model.
    task automatic step(input bit v, input bit w, input int sel, input int rd,
                        input bit st, input bit fl);
        valid_i  = v;
        RegWrt   = w;
        RegWData = sel[SEL_W-1:0];
        Rd       = rd[RD_W-1:0];
        stall    = st;
        flush    = fl;
        #1;
        check_model();
        @(posedge clk);
        model_step();
        #1;
        cyc++;
    endtask

    task automatic bubbles(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic flush_case(input bit with_stall);
        commits = 0;
        if (with_stall) begin
            step(1'b1, 1'b1, 1, 3, 1'b0, 1'b0);
            step(1'b1, 1'b1, 1, 2, 1'b0, 1'b0);
            step(1'b1, 1'b1, 1, 1, 1'b0, 1'b0);
            step(1'b0, 1'b0, 0, 0, 1'b1, 1'b1);
        end else begin
            step(1'b1, 1'b1, 1, 3, 1'b0, 1'b0);
            step(1'b1, 1'b1, 1, 2, 1'b0, 1'b0);
            step(1'b1, 1'b1, 1, 1, 1'b0, 1'b1);
        end
        bubbles(6);
        chk("flush_commits", commits, 1);
        chk("flush_rd", commit_rd, 3);
    endtask

    initial begin
        int c0;
        model_clear();

        // Held in reset: everything reads zero.
        #2;
        chk("rst0_RegWrtO", 32'(RegWrtO), 0);
        chk("rst0_q_hit", 32'(q_hit), 0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Asynchronous reset with three live entries in flight.
        q_rd = {5'd21, 5'd20};
        step(1'b1, 1'b1, 1, 20, 1'b0, 1'b0);
        step(1'b1, 1'b1, 2, 21, 1'b0, 1'b0);
        step(1'b1, 1'b1, 3, 22, 1'b0, 1'b0);
        step(1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
        reset = 1'b0;
        #1;
        chk("rst_RegWrtO", 32'(RegWrtO), 0);
        chk("rst_RegWDataO", 32'(RegWDataO), 0);
        chk("rst_RdO", 32'(RdO), 0);
        chk("rst_q_hit", 32'(q_hit), 0);
        chk("rst_q_stage", 32'(q_stage), 0);
        model_clear();
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Latency: single entry commits exactly once, DEPTH cycles after capture.
        commits = 0;
        c0 = cyc;
        step(1'b1, 1'b1, 3, 12, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++)
            step(1'b0, 1'b0, $urandom_range(0, 3), $urandom_range(0, 31), 1'b0, 1'b0);
        chk("lat_commits", commits, 1);
        chk("lat_cycle", commit_cyc - c0, DEPTH);
        chk("lat_rd", commit_rd, 12);

        // Stall with the entry parked in the last stage.
        commits = 0;
        c0 = cyc;
        step(1'b1, 1'b1, 2, 7, 1'b0, 1'b0);
        bubbles(3);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 0, 0, 1'b1, 1'b0);
            chk("stall_RdO", 32'(RdO), 7);
        end
        bubbles(3);
        chk("stall_commits", commits, 1);
        chk("stall_cycle", commit_cyc - c0, 7);
        chk("stall_rd", commit_rd, 7);

        // Flush kills the youngest KILL entries, with and without stall.
        flush_case(1'b0);
        flush_case(1'b1);

        // Query: Rd=5 in stages 2 and 4, Rd=6 without write in stage 1.
        q_rd = {5'd6, 5'd5};
        step(1'b1, 1'b1, 0, 5, 1'b0, 1'b0);
        step(1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 0, 5, 1'b0, 1'b0);
        step(1'b1, 1'b0, 0, 6, 1'b0, 1'b0);
        chk("qry_hit", 32'(q_hit), 32'h1);
        chk("qry_stage0", 32'(q_stage[SW-1:0]), 1);
        bubbles(DEPTH);

        // Zero register handling.
        q_rd = {5'd31, 5'd31};
        commits = 0;
        step(1'b1, 1'b1, 2, 31, 1'b0, 1'b0);
`ifdef REGWRITE_PIPE_XZR_FILTER_EN
        chk("xzr_hit", 32'(q_hit), 0);
`else
        chk("xzr_hit", 32'(q_hit), 32'h3);
`endif
        bubbles(6);
`ifdef REGWRITE_PIPE_XZR_FILTER_EN
        chk("xzr_commits", commits, 0);
`else
        chk("xzr_commits", commits, 1);
        chk("xzr_rd", commit_rd, 31);
`endif

        // Random traffic with occasional asynchronous reset pulses.
        for (int i = 0; i < 400; i++) begin
            int rd;
            rd   = ($urandom_range(0, 9) == 0) ? 31 : int'($urandom_range(0, 7));
            q_rd = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            if ($urandom_range(0, 9) == 0) q_rd[RD_W-1:0] = 5'd31;
            step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                 int'($urandom_range(0, 3)), rd,
                 $urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0);
            if (i % 150 == 149) begin
                reset = 1'b0;
                #1;
                chk("rnd_rst_RegWrtO", 32'(RegWrtO), 0);
                chk("rnd_rst_q_hit", 32'(q_hit), 0);
                model_clear();
                #1;
                reset = 1'b1;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/regwrite_pipe.md
Name: regwrite_pipe

Overview:
- Parametrised successor to the fixed 4-stage register-file write-control delay line in the pipelined CPU.
- Carries {RegWrt, RegWData select, Rd} from decode to writeback over DEPTH stages, with per-stage valid, pipeline stall and flush.
- Adds NQ hazard-query ports so decode can detect pending writes to its source registers and find the youngest producer stage.

Parameters:
- DEPTH, 4, number of register stages (>=2); input-to-output latency in cycles.
- SEL_W, 2, width of the RegWData writeback-source select.
- RD_W, 5, register address width.
- NQ, 2, number of hazard-query ports (Rn, Rm).
- KILL, 2, flush kills stages 1..KILL (KILL < DEPTH).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low; clears all stage valids.
- valid_i  in  1  entry at the input is a real instruction.
- RegWrt  in  1  instruction writes the register file.
- RegWData  in  SEL_W  writeback-source select.
- Rd  in  RD_W  destination register.
- stall  in  1  hold all stages.
- flush  in  1  kill stages 1..KILL.
- q_rd  in  NQ*RD_W  query addresses, packed; port k uses bits [k*RD_W +: RD_W].
- q_hit  out  NQ  pending write to q_rd[k] exists.
- q_stage  out  NQ*$clog2(DEPTH)  youngest matching stage, 0 = stage 1.
- RegWrtO  out  1  commit strobe to the register file.
- RegWDataO  out  SEL_W  select from the last stage.
- RdO  out  RD_W  destination from the last stage.

Behaviour:
- Stage s (1..DEPTH) holds {v, wr, sel, rd}. Stage 1 is loaded from the inputs; stage s is loaded from stage s-1.
- Reset (asynchronous, active-low): all v=0, wr=0, sel=0, rd=0 immediately, including mid-operation. Outputs then read RegWrtO=0, RegWDataO=0, RdO=0, q_hit=0, q_stage=0. The first capture happens on the first rising edge after reset is released.
- Latency: an entry sampled at edge n reaches stage DEPTH at edge n+DEPTH-1. RegWrtO is visible for the cycle after that edge. With DEPTH=4 the delay is 4 cycles.
- Normal edge (stall=0, flush=0): every stage shifts by one. The last stage's old contents are retired.
- stall=1, flush=0: all stages hold. valid_i is ignored; the upstream stage is responsible for holding it.
- flush=1 with stall=0: the shift happens, then the new stage 1..KILL valids are forced to 0. Stages KILL+1..DEPTH take the shifted values.
- flush=1 with stall=1: stages 1..KILL get v=0; all other stages hold. Flush takes priority over stall.
- Bubble insertion: valid_i=0 loads v=0. The payload is still loaded but is don't-care.
- Commit: RegWrtO = v[DEPTH] & wr[DEPTH] & ~stall. This is combinational gating on registered state, so a stalled entry commits exactly once. RegWDataO and RdO come straight from stage DEPTH regardless of v.
- Query port k matches stage s when v[s] & wr[s] & (rd[s]==q_rd[k]), all combinational.
  - q_hit[k] = OR over all stages.
  - q_stage[k] = lowest matching s-1, i.e. the youngest producer; 0 when there is no hit.
  - Multiple matches resolve to the youngest.
- Stage DEPTH participates in queries, including while its commit is happening in the same cycle.

Optional Feature:
- REGWRITE_PIPE_XZR_FILTER_EN
- Defined: any entry with Rd=={RD_W{1'b1}} (XZR) has wr forced to 0 at stage 1. It never commits and never produces a hit. A query for that address always returns q_hit=0.
- Undefined: XZR is treated as an ordinary register and the decode stage filters it.

Decomposition:
- Package regwrite_pkg holds:
  - the typedef struct packed wb_ctrl_t {logic v, wr; logic [SEL_W-1:0] sel; logic [RD_W-1:0] rd;};
  - localparam XZR_ADDR;
  - a function stage_idx_w(DEPTH) returning $clog2(DEPTH).
- One sub-module, regwrite_pipe_stage: a single wb_ctrl_t register with async active-low reset, hold (stall) and kill inputs, instantiated DEPTH times with a generate loop.
- Query priority logic stays in the top module.

Test Plan:
- Reset low mid-stream with 3 valid entries in flight -> all outputs read 0 immediately; after release, the first new entry commits exactly DEPTH cycles later.
- Latency, DEPTH=4: valid_i=1, RegWrt=1, RegWData=3, Rd=12 for one cycle -> RegWrtO=1, RegWDataO=3, RdO=12 for exactly one cycle, 4 cycles after capture.
- Stall: entry Rd=7 in stage 4, stall=1 for 3 cycles -> RegWrtO=0 while stalled, RdO=7 held; RegWrtO=1 for one cycle after stall drops.
- Flush, KILL=2: entries Rd=1 (stage 1), Rd=2 (stage 2), Rd=3 (stage 3), flush=1 -> only Rd=3 commits; repeat with stall=1 in the same cycle -> same outcome.
- Query: Rd=5 in stages 2 and 4, q_rd[0]=5, q_rd[1]=6 -> q_hit=2'b01, q_stage[0]=1; an entry with RegWrt=0 and Rd=6 -> q_hit[1]=0.
- XZR, macro defined: RegWrt=1, Rd=31 -> no RegWrtO; query 31 gives q_hit=0. Macro undefined -> commits with RdO=31 and q_hit=1.
